// File: rtl/shift_sequencer.sv
// Sequential 8-bit shifter. It moves one bit per clock and supports SLL, SRL, SRA and ROR.
// Right shifts and rotates reuse the left-shift datapath by bit-reversing the operand on the way in and on the way out.
module shift_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] din,
  input  logic [2:0] shamt,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t     state;
  logic [1:0] mode_q;
  logic [2:0] cnt;
  logic [7:0] work;
  logic       sign;
  logic       shin;

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // In the reversed domain, the incoming bit sits at the LSB end.
  // It is the sign bit for SRA and the wrapped-around MSB for ROR.
  always_comb begin
    shin = 1'b0;
    case (mode_q)
      MODE_SRA: shin = sign;
      MODE_ROR: shin = work[7];
      default:  shin = 1'b0;
    endcase
  end

  assign state_dbg = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= MODE_SLL;
      cnt    <= 3'd0;
      work   <= 8'h00;
      sign   <= 1'b0;
      dout   <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q <= mode;
            cnt    <= shamt;
            work   <= (mode == MODE_SLL) ? din : bitrev(din);
            sign   <= din[7];
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            work <= {work[6:0], shin};
            cnt  <= cnt - 3'd1;
          end else begin
            dout  <= (mode_q == MODE_SLL) ? work : bitrev(work);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
